// File: rtl/dll_ctrl_pkg.sv
// dll_ctrl_pkg: shared state encoding and default parameters for the DLL lock controller
package dll_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, SAR, TRACK} state_t;
  localparam int DEF_CODE_W = 10;
  localparam int DEF_SETTLE = 4;
  localparam int DEF_FILT_N = 4;
  localparam int DEF_LOCK_CNT = 8;
  function automatic int code_max(input int w);
    return (1 << w) - 1;
  endfunction
endpackage

// File: rtl/dll_vote_filter.sv
// dll_vote_filter: signed vote accumulator turning phase-detector samples into +/-1 step pulses
module dll_vote_filter
  import dll_ctrl_pkg::*;
#(
  parameter int FILT_N = DEF_FILT_N
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic sample,
  input  logic up,
  input  logic dn,
  output logic step_up,
  output logic step_dn
);
  localparam int VW = $clog2(FILT_N + 1) + 1;
  localparam logic signed [VW-1:0] ONE = VW'(1);
  localparam logic signed [VW-1:0] TOP = VW'(FILT_N - 1);
  localparam logic signed [VW-1:0] BOT = VW'(1 - FILT_N);
  logic signed [VW-1:0] vote, vote_nx;
  logic up_only, dn_only;
  assign up_only = up && !dn;
  assign dn_only = dn && !up;
  // a step fires on the sample that would carry the vote to +/-FILT_N, so the
  // stored vote never holds the extreme value itself
  assign step_up = sample && up_only && vote >= TOP;
  assign step_dn = sample && dn_only && vote <= BOT;
  always_comb begin
    vote_nx = clear || (sample && (step_up || step_dn)) ? '0 :
              !sample ? vote :
              up_only ? (vote < 0 ? ONE : vote + ONE) :
              dn_only ? (vote > 0 ? -ONE : vote - ONE) : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) vote <= '0;
    else vote <= vote_nx;
endmodule

// File: rtl/dll_lock_ctrl.sv
// dll_lock_ctrl: SAR acquisition then filtered up/down tracking of the DLL delay code
module dll_lock_ctrl
  import dll_ctrl_pkg::*;
#(
  parameter int CODE_W   = DEF_CODE_W,
  parameter int SETTLE   = DEF_SETTLE,
  parameter int FILT_N   = DEF_FILT_N,
  parameter int LOCK_CNT = DEF_LOCK_CNT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pd_up,
  input  logic              pd_dn,
  output logic [CODE_W-1:0] q,
  output logic              locked,
  output logic              sat,
  output logic              busy
);
  localparam int SW = $clog2(SETTLE + 1);
  localparam int IW = $clog2(CODE_W);
  localparam int LW = $clog2(LOCK_CNT + 1);
  localparam logic [CODE_W-1:0] CODE_MAX = CODE_W'(code_max(CODE_W));
  localparam logic [CODE_W-1:0] MID = CODE_W'(1) << (CODE_W - 1);
  localparam logic [SW-1:0] SETTLE_V = SW'(SETTLE);
  localparam logic [LW-1:0] LC = LW'(LOCK_CNT);
  state_t state, state_nx;
  logic [CODE_W-1:0] q_nx;
  logic [SW-1:0] settle, settle_nx;
  logic [IW-1:0] idx, idx_nx;
  logic [LW-1:0] lock_cnt, lock_cnt_nx;
  logic locked_nx, sat_nx, last_up, last_up_nx, last_dn, last_dn_nx;
  logic sample, step_up, step_dn, blocked;
  assign sample = settle == '0;
  assign busy = state != IDLE;
  assign blocked = step_up ? q == CODE_MAX : q == '0;
  dll_vote_filter #(.FILT_N(FILT_N)) u_filt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (start || state != TRACK),
    .sample (sample && state == TRACK && !start),
    .up     (pd_up),
    .dn     (pd_dn),
    .step_up(step_up),
    .step_dn(step_dn)
  );
  always_comb begin
    state_nx = state;
    q_nx = q;
    idx_nx = idx;
    settle_nx = sample ? settle : settle - 1'b1;
    lock_cnt_nx = lock_cnt;
    locked_nx = locked;
    sat_nx = 1'b0;
    last_up_nx = last_up;
    last_dn_nx = last_dn;
    if (start) begin
      state_nx = SAR;
      q_nx = MID;
      idx_nx = IW'(CODE_W - 1);
      settle_nx = SETTLE_V;
      lock_cnt_nx = '0;
      locked_nx = 1'b0;
      last_up_nx = 1'b0;
      last_dn_nx = 1'b0;
    end else if (state == SAR && sample) begin
      if (pd_dn && !pd_up) q_nx[idx] = 1'b0;
      if (idx != '0) begin
        q_nx[idx - 1'b1] = 1'b1;
        idx_nx = idx - 1'b1;
      end else begin
        state_nx = TRACK;
        lock_cnt_nx = '0;
      end
      settle_nx = SETTLE_V;
    end else if (state == TRACK) begin
      // a full step-free window also forgets the last step direction, so only
      // back-to-back same-direction steps can drop lock
      if (lock_cnt == LC) begin
        locked_nx = 1'b1;
        last_up_nx = 1'b0;
        last_dn_nx = 1'b0;
      end
      if (step_up || step_dn) begin
        lock_cnt_nx = '0;
        if (blocked) begin
          sat_nx = 1'b1;
          locked_nx = 1'b0;
        end else begin
          q_nx = step_up ? q + 1'b1 : q - 1'b1;
          settle_nx = SETTLE_V;
          if ((step_up && last_up_nx) || (step_dn && last_dn_nx)) locked_nx = 1'b0;
          last_up_nx = step_up;
          last_dn_nx = step_dn;
        end
      end else if (sample && lock_cnt != LC) lock_cnt_nx = lock_cnt + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      q <= '0;
      settle <= '0;
      idx <= '0;
      lock_cnt <= '0;
      locked <= 1'b0;
      sat <= 1'b0;
      last_up <= 1'b0;
      last_dn <= 1'b0;
    end else begin
      state <= state_nx;
      q <= q_nx;
      settle <= settle_nx;
      idx <= idx_nx;
      lock_cnt <= lock_cnt_nx;
      locked <= locked_nx;
      sat <= sat_nx;
      last_up <= last_up_nx;
      last_dn <= last_dn_nx;
    end
endmodule
